nor_dcdl_cal_ctrl: RTL and testbench

- Calibration sequencer for a digitally controlled delay line built from chained NOR delay cells in the analog core model.
- Sweeps the delay code upward from 0 and waits a settle interval after each code change.
- Averages phase-detector early/late samples at each code; locks on the first code where the majority flips from early to late.
- Sits between the core digital control and the delay-line code input. Supports a manual code override when no calibration is running.

---
 rtl/nor_dcdl_cal_ctrl_if.sv | 29 ++
 rtl/nor_dcdl_cal_ctrl.sv | 135 +++++++++++++
 tb/tb_nor_dcdl_cal_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/nor_dcdl_cal_ctrl_if.sv
// nor_dcdl_cal_ctrl_if
//   Control/status bundle between the core digital control (master) and the
//   NOR delay-line calibration sequencer (slave).
//   master drives: cal_start, pd_valid, pd_early, code_ovr_en, code_ovr
//   slave drives : dly_code, lock_code, busy, done, cal_fail
interface nor_dcdl_cal_ctrl_if #(
  parameter int N_CODE = 6
);
  logic              cal_start;
  logic              pd_valid;
  logic              pd_early;
  logic              code_ovr_en;
  logic [N_CODE-1:0] code_ovr;
  logic [N_CODE-1:0] dly_code;
  logic [N_CODE-1:0] lock_code;
  logic              busy;
  logic              done;
  logic              cal_fail;

  modport master (
    output cal_start, pd_valid, pd_early, code_ovr_en, code_ovr,
    input  dly_code, lock_code, busy, done, cal_fail
  );

  modport slave (
    input  cal_start, pd_valid, pd_early, code_ovr_en, code_ovr,
    output dly_code, lock_code, busy, done, cal_fail
  );
endinterface

// File: rtl/nor_dcdl_cal_ctrl.sv
// nor_dcdl_cal_ctrl
//   Calibration sequencer for a NOR-cell digitally controlled delay line.
//   Sweeps the delay code upward from 0, settles N_SETTLE cycles after every
//   code change, averages N_AVG phase-detector samples, and locks on the first
//   code whose majority flips from early to late. A manual code override is
//   honoured whenever no sweep is running.
// Ports:
//   clk   - clock
//   rstb  - asynchronous active-low reset
//   cal   - slave side of nor_dcdl_cal_ctrl_if
//           in : cal_start, pd_valid, pd_early, code_ovr_en, code_ovr
//           out: dly_code, lock_code, busy, done, cal_fail (all registered)
module nor_dcdl_cal_ctrl #(
  parameter int N_CODE   = 6,
  parameter int N_SETTLE = 8,
  parameter int N_AVG    = 16
) (
  input  logic                 clk,
  input  logic                 rstb,
  nor_dcdl_cal_ctrl_if.slave   cal
);

  localparam int SW = (N_SETTLE > 1) ? $clog2(N_SETTLE) : 1;
  localparam int AW = $clog2(N_AVG + 1);

  localparam logic [SW-1:0]   SETTLE_LOAD = SW'(N_SETTLE - 1);
  localparam logic [AW-1:0]   AVG_LAST    = AW'(N_AVG - 1);
  localparam logic [AW+1:0]   AVG_CMP     = (AW+2)'(N_AVG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DECIDE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t            state_q;
  logic [N_CODE-1:0] dly_q;
  logic [N_CODE-1:0] lock_q;
  logic              busy_q;
  logic              done_q;
  logic              fail_q;
  logic [SW-1:0]     settle_q;
  logic [AW-1:0]     smp_q;
  logic [AW-1:0]     early_q;

  // Majority early: early_cnt*2 > N_AVG; a tie is treated as late.
  logic early_maj;
  assign early_maj = {1'b0, early_q, 1'b0} > AVG_CMP;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      dly_q    <= '0;
      lock_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      settle_q <= '0;
      smp_q    <= '0;
      early_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (cal.cal_start) begin
            dly_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            settle_q <= SETTLE_LOAD;
            state_q  <= S_SETTLE;
          end else if (cal.code_ovr_en) begin
            dly_q <= cal.code_ovr;
          end
        end

        S_SETTLE: begin
          if (settle_q == '0) begin
            smp_q   <= '0;
            early_q <= '0;
            state_q <= S_MEASURE;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end

        S_MEASURE: begin
          if (cal.pd_valid) begin
            smp_q   <= smp_q + 1'b1;
            early_q <= early_q + AW'(cal.pd_early);
            if (smp_q == AVG_LAST) state_q <= S_DECIDE;
          end
        end

        S_DECIDE: begin
          // Any code above 0 is only reached after an early decision, so a
          // late result there is always an early->late transition.
          if (!early_maj) begin
            if (dly_q == '0) begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              dly_q   <= '0;
              state_q <= S_FAIL;
            end else begin
              lock_q  <= dly_q;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
          end else if (dly_q == '1) begin
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            dly_q   <= '0;
            state_q <= S_FAIL;
          end else begin
            dly_q    <= dly_q + 1'b1;
            settle_q <= SETTLE_LOAD;
            state_q  <= S_SETTLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cal.dly_code  = dly_q;
  assign cal.lock_code = lock_q;
  assign cal.busy      = busy_q;
  assign cal.done      = done_q;
  assign cal.cal_fail  = fail_q;

endmodule

// File: tb/tb_nor_dcdl_cal_ctrl.sv
// tb_nor_dcdl_cal_ctrl
//   Self-checking bench for nor_dcdl_cal_ctrl. A phase-detector plant answers
//   early/late from the current delay code; a sweep-level reference model
//   predicts the outcome code and the exact edge on which the sweep finishes.
module tb_nor_dcdl_cal_ctrl;

  localparam int N_CODE   = 6;
  localparam int N_SETTLE = 8;
  localparam int N_AVG    = 16;
  localparam int NCODES   = 1 << N_CODE;
  localparam int PV_LEN   = 8192;

  logic clk;
  logic rstb;

  nor_dcdl_cal_ctrl_if #(.N_CODE(N_CODE)) bus ();

  nor_dcdl_cal_ctrl #(
    .N_CODE   (N_CODE),
    .N_SETTLE (N_SETTLE),
    .N_AVG    (N_AVG)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .cal  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int exp_lock = 0;
  bit pv [PV_LEN];
  bit tog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".dly"},  32'(bus.dly_code),  0);
    check({tag, ".lock"}, 32'(bus.lock_code), 0);
    check({tag, ".busy"}, 32'(bus.busy),      0);
    check({tag, ".done"}, 32'(bus.done),      0);
    check({tag, ".fail"}, 32'(bus.cal_fail),  0);
  endtask

  // Outcome of a sweep from per-code early counts (plant: early below thr,
  // exactly half early at code tie, late elsewhere).
  task automatic model(input int thr, input int tie, output bit xfail,
                       output int xcode, output int ncodes);
    int cnt;
    xfail = 1'b1; xcode = 0; ncodes = NCODES;
    for (int c = 0; c < NCODES; c++) begin
      cnt = (c < thr) ? N_AVG : ((c == tie) ? N_AVG / 2 : 0);
      if (!(cnt * 2 > N_AVG)) begin
        ncodes = c + 1;
        if (c == 0) begin xfail = 1'b1; xcode = 0; end
        else        begin xfail = 1'b0; xcode = c; end
        return;
      end
    end
  endtask

  // Finishing edge relative to the cal_start edge, given the valid pattern.
  function automatic int end_edge(input int ncodes);
    int e = 0;
    int n;
    for (int i = 0; i < ncodes; i++) begin
      e += N_SETTLE;
      n = 0;
      while (n < N_AVG && e < PV_LEN - 2) begin
        e++;
        if (pv[e]) n++;
      end
      e++;
    end
    return e;
  endfunction

  task automatic run_sweep(input string nm, input int thr, input int tie,
                           input int mode, input bit noise);
    bit xfail;
    int xcode, ncodes, e_end, code;
    for (int i = 0; i < PV_LEN; i++)
      case (mode)
        0:       pv[i] = 1'b1;
        1:       pv[i] = (i % 2) == 1;
        default: pv[i] = ($urandom_range(0, 3) != 0);
      endcase
    model(thr, tie, xfail, xcode, ncodes);
    e_end = end_edge(ncodes);

    bus.cal_start   = 1'b1;
    bus.code_ovr_en = 1'b0;
    bus.pd_valid    = 1'b0;
    tog             = 1'b0;
    step();
    check({nm, ".start_busy"}, 32'(bus.busy),     1);
    check({nm, ".start_done"}, 32'(bus.done),     0);
    check({nm, ".start_fail"}, 32'(bus.cal_fail), 0);
    check({nm, ".start_dly"},  32'(bus.dly_code), 0);
    bus.cal_start = 1'b0;

    for (int r = 1; r <= e_end; r++) begin
      bus.pd_valid = pv[r];
      code = int'(bus.dly_code);
      if (!pv[r])            bus.pd_early = 1'($urandom);
      else if (code < thr)   bus.pd_early = 1'b1;
      else if (code == tie) begin bus.pd_early = tog; tog = ~tog; end
      else                   bus.pd_early = 1'b0;
      if (noise) begin
        bus.cal_start   = ($urandom_range(0, 7) == 0);
        bus.code_ovr_en = 1'($urandom);
        bus.code_ovr    = 6'($urandom);
      end
      step();
      if (r == e_end - 1) begin
        check({nm, ".prev_busy"}, 32'(bus.busy), 1);
        check({nm, ".prev_done"}, 32'(bus.done), 0);
      end
    end
    bus.cal_start   = 1'b0;
    bus.code_ovr_en = 1'b0;
    bus.pd_valid    = 1'b0;

    check({nm, ".busy"}, 32'(bus.busy),     0);
    check({nm, ".done"}, 32'(bus.done),     32'(!xfail));
    check({nm, ".fail"}, 32'(bus.cal_fail), 32'(xfail));
    check({nm, ".dly"},  32'(bus.dly_code), xfail ? 0 : 32'(xcode));
    if (!xfail) exp_lock = xcode;
    check({nm, ".lock"}, 32'(bus.lock_code), 32'(exp_lock));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstb            = 1'b0;
    bus.cal_start   = 1'b0;
    bus.pd_valid    = 1'b0;
    bus.pd_early    = 1'b0;
    bus.code_ovr_en = 1'b0;
    bus.code_ovr    = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.cal_start   = 1'($urandom);
      bus.pd_valid    = 1'($urandom);
      bus.pd_early    = 1'($urandom);
      bus.code_ovr_en = 1'($urandom);
      bus.code_ovr    = 6'($urandom);
      step();
      check_zero("rst_hold");
    end
    bus.cal_start   = 1'b0;
    bus.code_ovr_en = 1'b0;
    rstb = 1'b1;
    step(); step();
    check_zero("rst_release");

    run_sweep("nominal", 23, -1, 0, 1'b0);

    bus.code_ovr_en = 1'b1;
    bus.code_ovr    = 6'h2A;
    step();
    check("ovr.dly",  32'(bus.dly_code), 32'h2A);
    check("ovr.done", 32'(bus.done),     1);
    bus.code_ovr_en = 1'b0;
    bus.code_ovr    = 6'h15;
    step();
    check("ovr.hold", 32'(bus.dly_code), 32'h2A);

    run_sweep("all_early", NCODES, -1, 0, 1'b0);
    run_sweep("all_late",  0,      -1, 0, 1'b0);
    run_sweep("tie",       5,       5, 0, 1'b0);
    run_sweep("gapped",    23,     -1, 1, 1'b1);
    for (int k = 0; k < 3; k++)
      run_sweep("random", $urandom_range(1, NCODES - 1), $urandom_range(0, NCODES - 1), 2, 1'b1);

    // Reset asserted mid-MEASURE.
    bus.cal_start = 1'b1;
    step();
    bus.cal_start = 1'b0;
    bus.pd_valid  = 1'b1;
    bus.pd_early  = 1'b1;
    for (int i = 0; i < 12; i++) step();
    #2 rstb = 1'b0;
    #1 check_zero("mid_rst");
    step();
    rstb = 1'b1;
    bus.pd_valid = 1'b0;
    exp_lock = 0;
    step();
    check_zero("mid_rst_rel");

    run_sweep("post_rst", 10, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
